// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid register).
// Decouples in_ready from out_ready so back-pressure never forms a
// combinational path through the stage. An empty stage presents an all-zero
// control word (bubble). flush kills held and incoming entries synchronously.
module pipe_stage_buf #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic accept;
    logic pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = HALF;
            HALF: begin
                if (accept && !pop)      state_nxt = FULL;
                else if (pop && !accept) state_nxt = EMPTY;
            end
            FULL: if (pop) state_nxt = HALF;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // Output decode: handshake, occupancy and bubble masking of control.
    always_comb begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state)
            HALF: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
        in_ready = (state != FULL) && !flush;
        out_ctrl = out_valid ? main_ctrl : '0;
    end

    assign out_data = main_data;

    // Payload registers: load main/skid on accept, promote skid on pop from FULL.
    // NOTE: payload registers are reset explicitly so out_data reads zero
    // after reset instead of whatever power-up value the flops hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Data is left alone; clearing ctrl alone guarantees a bubble.
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                HALF: begin
                    if (accept && pop) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: the driver pushes every entry it
// expects to be accepted; a negedge monitor compares the head and handshake
// outputs and retires entries as the DUT delivers them.
module tb_pipe_stage_buf;

    localparam int DW = 160;
    localparam int CW = 13;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    ent_t     sb_q[$];
    int       occ_m = 0;
    int       n_cmp = 0;
    int       n_err = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge; push expected entry on accept.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        logic acc, pp;
        int   nxt;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        acc = v && (occ_m != 2) && !fl;
        pp  = (occ_m != 0) && ordy;
        if (acc) sb_q.push_back('{d: d, c: c});
        nxt = fl ? 0 : occ_m + int'(acc) - int'(pp);
        @(posedge clk);
        #1;
        occ_m = nxt;
    endtask

    // Monitor: handshake/occupancy against the model, head against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("occupancy", DW'(occupancy), DW'(occ_m));
            check("in_ready", DW'(in_ready), DW'((occ_m != 2) && !flush));
            check("out_valid", DW'(out_valid), DW'(occ_m != 0));
            if (!out_valid) begin
                check("bubble_ctrl", DW'(out_ctrl), '0);
            end else if (sb_q.size() == 0) begin
                check("sb_underflow", DW'(out_valid), '0);
            end else begin
                check("out_data", out_data, sb_q[0].d);
                check("out_ctrl", DW'(out_ctrl), DW'(sb_q[0].c));
                if (out_ready) void'(sb_q.pop_front());
            end
            if (flush) sb_q.delete();
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i += 32) r[i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_occupancy", DW'(occupancy), '0);
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_ctrl", DW'(out_ctrl), '0);
        check("rst_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Pass-through at full throughput.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 13'h1A5, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: fill, hold, then drain in order.
        step(1'b1, DW'('hA), 13'h0AA, 1'b0, 1'b0);
        step(1'b1, DW'('hB), 13'h0BB, 1'b0, 1'b0);
        step(1'b1, DW'('hC), 13'h0CC, 1'b0, 1'b0);  // refused while FULL
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush from FULL with an incoming entry that must be dropped.
        step(1'b1, DW'('h11), 13'h1FFF, 1'b0, 1'b0);
        step(1'b1, DW'('h22), 13'h1FFF, 1'b0, 1'b0);
        step(1'b1, DW'('h55), 13'h1FFF, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush from FULL while the head is being popped.
        step(1'b1, DW'('h31), 13'h0031, 1'b0, 1'b0);
        step(1'b1, DW'('h32), 13'h0032, 1'b0, 1'b0);
        step(1'b1, DW'('h33), 13'h0033, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Simultaneous accept and pop in HALF.
        step(1'b1, DW'('h5), 13'h0005, 1'b1, 1'b0);
        step(1'b1, DW'('h6), 13'h0006, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Async reset between edges while FULL.
        step(1'b1, DW'('h77), 13'h0077, 1'b0, 1'b0);
        step(1'b1, DW'('h88), 13'h0088, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_occupancy", DW'(occupancy), '0);
        check("arst_out_valid", DW'(out_valid), '0);
        check("arst_out_data", out_data, '0);
        check("arst_out_ctrl", DW'(out_ctrl), '0);
        check("arst_in_ready", DW'(in_ready), DW'(1));
        sb_q.delete();
        occ_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, DW'('h99), 13'h0099, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 99) < 60), rnd_data(), CW'($urandom),
                 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3));
        end

        // Drain and confirm nothing was lost or duplicated.
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("sb_drained", DW'(sb_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
